// File: rtl/mem_if.sv
// Memory port between the LC-3b MAR/MDR side (master) and the memory responder (slave).
interface mem_if;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_resp;
    logic        protocol_err;

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_rdata, mem_resp, protocol_err
    );

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_rdata, mem_resp, protocol_err
    );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency word/byte memory responder for the LC-3b memory port.
// Each accepted request completes with a one-cycle mem_resp after LATENCY cycles.
module mem_responder #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned LATENCY   = 3
) (
    input logic   clk,
    input logic   reset,
    mem_if.slave  bus
);

    localparam int unsigned Words = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   read_q, write_q;
    logic [15:0]            addr_q;
    logic [15:0]            wdata_q;
    logic [1:0]             be_q;
    logic [15:0]            rdata_q;
    logic                   err_q;
    logic [15:0]            mem_q [Words];

    logic                   accept;
    logic                   capture;
    logic                   commit;
    logic                   err_set;
    logic                   read_sel;
    logic [ADDR_BITS-1:0]   rd_idx;
    logic [ADDR_BITS-1:0]   wr_idx;

    assign wr_idx = addr_q[ADDR_BITS:1];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        commit   = 1'b0;
        err_set  = 1'b0;
        read_sel = read_q;
        rd_idx   = addr_q[ADDR_BITS:1];

        unique case (state_q)
            StIdle: begin
                // With LATENCY=1 RESP is entered straight from IDLE, so read from the live bus.
                read_sel = bus.mem_read & ~bus.mem_write;
                rd_idx   = bus.mem_address[ADDR_BITS:1];
                if (bus.mem_read || bus.mem_write) begin
                    accept  = 1'b1;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? StResp : StWait;
                    err_set = bus.mem_read & bus.mem_write;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
                commit  = write_q;
            end
            default: state_d = StIdle;
        endcase

        if (state_q != StIdle &&
            ((!bus.mem_read && !bus.mem_write) || bus.mem_address != addr_q)) begin
            err_set = 1'b1;
        end

        capture = (state_d == StResp) && (state_q != StResp) && read_sel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            for (int unsigned i = 0; i < Words; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                read_q  <= bus.mem_read & ~bus.mem_write;
                write_q <= bus.mem_write;
                addr_q  <= bus.mem_address;
                wdata_q <= bus.mem_wdata;
                be_q    <= bus.mem_byte_enable;
            end
            if (capture) rdata_q <= mem_q[rd_idx];
            if (commit) begin
                if (be_q[0]) mem_q[wr_idx][7:0]  <= wdata_q[7:0];
                if (be_q[1]) mem_q[wr_idx][15:8] <= wdata_q[15:8];
            end
            if (err_set) err_q <= 1'b1;
        end
    end

    assign bus.mem_rdata    = rdata_q;
    assign bus.mem_resp     = (state_q == StResp);
    assign bus.protocol_err = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: scoreboard of expected read data against a word model,
// plus two extra instances at LATENCY=1 and LATENCY=15 for the latency sweep.
module tb_mem_responder;

    localparam int Lat = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_if bus ();
    mem_if bus1 ();
    mem_if bus15 ();

    mem_responder #(.ADDR_BITS(8), .LATENCY(3))  dut   (.clk(clk), .reset(reset), .bus(bus));
    mem_responder #(.ADDR_BITS(8), .LATENCY(1))  dut1  (.clk(clk), .reset(reset), .bus(bus1));
    mem_responder #(.ADDR_BITS(8), .LATENCY(15)) dut15 (.clk(clk), .reset(reset), .bus(bus15));

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] model [256];
    logic [15:0] exp_q [$];
    logic [15:0] last_rd;

    task automatic clear_model();
        foreach (model[i]) model[i] = 16'h0000;
        exp_q.delete();
        last_rd = 16'h0000;
    endtask

    task automatic set_bus(input logic rd, input logic wr, input logic [1:0] be,
                           input logic [15:0] a, input logic [15:0] wd);
        bus.mem_read        = rd;
        bus.mem_write       = wr;
        bus.mem_byte_enable = be;
        bus.mem_address     = a;
        bus.mem_wdata       = wd;
    endtask

    task automatic set_sweep(input logic sel15, input logic rd, input logic wr,
                             input logic [15:0] a, input logic [15:0] wd);
        if (sel15) begin
            bus15.mem_read = rd; bus15.mem_write = wr; bus15.mem_byte_enable = 2'b11;
            bus15.mem_address = a; bus15.mem_wdata = wd;
        end else begin
            bus1.mem_read = rd; bus1.mem_write = wr; bus1.mem_byte_enable = 2'b11;
            bus1.mem_address = a; bus1.mem_wdata = wd;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        set_bus(1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
        set_sweep(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        set_sweep(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        clear_model();
    endtask

    task automatic check_err(input logic want, input string name);
        @(negedge clk);
        n_checks++;
        if (bus.protocol_err !== want) begin
            n_fail++;
            $display("FAIL %s protocol_err: got %b want %b", name, bus.protocol_err, want);
        end
    endtask

    // Drives one request in the next cycle and checks mem_resp over cycles 0..Lat.
    task automatic run_op(input logic rd, input logic wr, input logic [1:0] be,
                          input logic [15:0] a, input logic [15:0] wd, input string name);
        logic [7:0] idx;
        logic       is_rd;
        @(posedge clk); #1;
        set_bus(rd, wr, be, a, wd);
        idx   = a[8:1];
        is_rd = rd && !wr;
        if (is_rd) exp_q.push_back(model[idx]);
        if (wr) begin
            if (be[0]) model[idx][7:0]  = wd[7:0];
            if (be[1]) model[idx][15:8] = wd[15:8];
        end
        for (int c = 0; c <= Lat; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.mem_resp !== (c == Lat)) begin
                n_fail++;
                $display("FAIL %s resp cycle %0d: got %b want %b", name, c, bus.mem_resp, c == Lat);
            end
            if (c == Lat) begin
                logic [15:0] e;
                e = is_rd ? exp_q.pop_front() : last_rd;
                n_checks++;
                if (bus.mem_rdata !== e) begin
                    n_fail++;
                    $display("FAIL %s rdata: got %h want %h", name, bus.mem_rdata, e);
                end
                last_rd = e;
            end
        end
    endtask

    task automatic go_idle(input string name);
        @(posedge clk); #1;
        set_bus(1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
        @(negedge clk);
        n_checks++;
        if (bus.mem_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL %s resp after done: got %b want 0", name, bus.mem_resp);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++;
        if (bus.mem_resp !== 1'b0 || bus.mem_rdata !== 16'h0000 || bus.protocol_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset outputs: got resp=%b rdata=%h err=%b want 0/0000/0",
                     bus.mem_resp, bus.mem_rdata, bus.protocol_err);
        end
        run_op(1'b1, 1'b0, 2'b00, 16'h00A0, 16'h0, "reset_rd");
        go_idle("reset_rd");
    endtask

    task automatic test_word_rw();
        run_op(1'b0, 1'b1, 2'b11, 16'h0010, 16'hBEEF, "word_wr");
        run_op(1'b1, 1'b0, 2'b00, 16'h0010, 16'h0, "word_rd");
        go_idle("word_rd");
    endtask

    task automatic test_bytes();
        run_op(1'b0, 1'b1, 2'b01, 16'h0010, 16'h12AB, "byte_lo_wr");
        go_idle("byte_lo_wr");
        run_op(1'b1, 1'b0, 2'b00, 16'h0010, 16'h0, "byte_lo_rd");
        go_idle("byte_lo_rd");
        run_op(1'b0, 1'b1, 2'b10, 16'h0011, 16'h3400, "byte_hi_wr");
        go_idle("byte_hi_wr");
        run_op(1'b1, 1'b0, 2'b00, 16'h0210, 16'h0, "alias_rd");
        go_idle("alias_rd");
        run_op(1'b0, 1'b1, 2'b00, 16'h0010, 16'hFFFF, "be00_wr");
        run_op(1'b1, 1'b0, 2'b00, 16'h0010, 16'h0, "be00_rd");
        go_idle("be00_rd");
        check_err(1'b0, "clean_ops");
    endtask

    task automatic test_err_both();
        run_op(1'b1, 1'b1, 2'b11, 16'h0030, 16'h5555, "rw_both");
        go_idle("rw_both");
        check_err(1'b1, "rw_both");
        run_op(1'b1, 1'b0, 2'b00, 16'h0030, 16'h0, "rw_both_rd");
        go_idle("rw_both_rd");
        check_err(1'b1, "rw_both_sticky");
        do_reset();
        check_err(1'b0, "err_cleared");
    endtask

    // Read of a pre-written word, disturbed in cycle 1 (dropped) or cycle 2 (address changed).
    task automatic test_midop(input logic change_addr, input string name);
        run_op(1'b0, 1'b1, 2'b11, 16'h0040, 16'hA5A5, {name, "_wr"});
        go_idle(name);
        @(posedge clk); #1;
        set_bus(1'b1, 1'b0, 2'b00, 16'h0040, 16'h0);
        exp_q.push_back(model[8'h20]);
        for (int c = 0; c <= Lat; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                if (!change_addr && c == 1) set_bus(1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
                if (change_addr && c == 2) bus.mem_address = 16'h0042;
            end
            @(negedge clk);
            n_checks++;
            if (bus.mem_resp !== (c == Lat)) begin
                n_fail++;
                $display("FAIL %s resp cycle %0d: got %b want %b", name, c, bus.mem_resp, c == Lat);
            end
            if (c == Lat) begin
                logic [15:0] e;
                e = exp_q.pop_front();
                n_checks++;
                if (bus.mem_rdata !== e) begin
                    n_fail++;
                    $display("FAIL %s rdata: got %h want %h", name, bus.mem_rdata, e);
                end
            end
        end
        go_idle(name);
        check_err(1'b1, name);
        do_reset();
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        set_bus(1'b0, 1'b1, 2'b11, 16'h0020, 16'hFFFF);
        for (int c = 0; c < 6; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                if (c == 2) begin
                    reset = 1'b1;
                    set_bus(1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
                end
                if (c == 3) reset = 1'b0;
            end
            @(negedge clk);
            n_checks++;
            if (bus.mem_resp !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid resp cycle %0d: got %b want 0", c, bus.mem_resp);
            end
        end
        clear_model();
        run_op(1'b1, 1'b0, 2'b00, 16'h0020, 16'h0, "reset_mid_rd");
        go_idle("reset_mid_rd");
        check_err(1'b0, "reset_mid");
    endtask

    task automatic test_back_to_back();
        run_op(1'b0, 1'b1, 2'b11, 16'h0010, 16'h1234, "held_wr");
        go_idle("held_wr");
        run_op(1'b1, 1'b0, 2'b00, 16'h0010, 16'h0, "held_rd1");
        run_op(1'b1, 1'b0, 2'b00, 16'h0010, 16'h0, "held_rd2");
        go_idle("held_rd2");
        check_err(1'b0, "held");
    endtask

    task automatic sweep_op(input logic rd, input logic wr, input logic [15:0] a,
                            input logic [15:0] wd, input logic [15:0] e, input string name);
        @(posedge clk); #1;
        set_sweep(1'b0, rd, wr, a, wd);
        set_sweep(1'b1, rd, wr, a, wd);
        for (int c = 0; c <= 16; c++) begin
            @(negedge clk);
            n_checks += 2;
            if (bus1.mem_resp !== (c == 1)) begin
                n_fail++;
                $display("FAIL %s lat1 resp cycle %0d: got %b want %b", name, c, bus1.mem_resp, c == 1);
            end
            if (bus15.mem_resp !== (c == 15)) begin
                n_fail++;
                $display("FAIL %s lat15 resp cycle %0d: got %b want %b", name, c, bus15.mem_resp, c == 15);
            end
            if (rd && c == 1) begin
                n_checks++;
                if (bus1.mem_rdata !== e) begin
                    n_fail++;
                    $display("FAIL %s lat1 rdata: got %h want %h", name, bus1.mem_rdata, e);
                end
            end
            if (rd && c == 15) begin
                n_checks++;
                if (bus15.mem_rdata !== e) begin
                    n_fail++;
                    $display("FAIL %s lat15 rdata: got %h want %h", name, bus15.mem_rdata, e);
                end
            end
            @(posedge clk); #1;
            if (c == 1)  set_sweep(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
            if (c == 15) set_sweep(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        end
    endtask

    task automatic test_latency_sweep();
        sweep_op(1'b0, 1'b1, 16'h0004, 16'hCAFE, 16'h0000, "sweep_wr");
        sweep_op(1'b1, 1'b0, 16'h0004, 16'h0000, 16'hCAFE, "sweep_rd");
    endtask

    initial begin
        reset = 1'b1;
        set_bus(1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
        set_sweep(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        set_sweep(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        clear_model();
        test_reset();
        test_word_rw();
        test_bytes();
        test_err_both();
        test_midop(1'b0, "drop");
        test_midop(1'b1, "addr_change");
        test_reset_mid();
        test_back_to_back();
        test_latency_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
